// File: rtl/pkt_gen_output_arbiter.sv
// pkt_gen_output_arbiter: merges NUM_QUEUES packet streams onto one datapath,
// whole packets only, round-robin among enabled non-empty queues.
// Ports:
//   clk, reset_n             clock; asynchronous active-low reset (deassert synchronised)
//   in_data/in_ctrl/in_wr    per-queue word input, queue q at slice q
//   in_rdy                   per-queue ready (input FIFO not nearly full)
//   queue_enable             per-queue arbitration eligibility
//   out_data/out_ctrl/out_wr registered merged output word
//   out_rdy                  downstream may accept a word
//   cur_queue                granted queue index
//   pkt_done                 pulse with the out_wr of each EOP word
// Optional: `define PKT_ARB_STRICT_PRIO_EN gives queue 0 strict priority.
module pkt_gen_output_arbiter #(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    output logic [NUM_QUEUES-1:0]            in_rdy,
    input  logic [NUM_QUEUES-1:0]            queue_enable,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [2:0]                       cur_queue,
    output logic                             pkt_done
);
    localparam int QW = $clog2(NUM_QUEUES);
    localparam int WW = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [2:0] LAST_Q = 3'(NUM_QUEUES - 1);

    typedef enum logic {IDLE, XFER} state_t;

    logic sync1_q, rst_n_q;
    state_t state_q, state_d;
    logic [2:0] cur_queue_q, cur_queue_d, last_grant_q, last_grant_d, idx;
    logic seen_data_q, seen_data_d, out_wr_q, out_wr_d, pkt_done_q, pkt_done_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic [WW-1:0] mem_q [NUM_QUEUES][4];
    logic [WW-1:0] mem_d [NUM_QUEUES][4];
    logic [1:0] wr_ptr_q [NUM_QUEUES];
    logic [1:0] wr_ptr_d [NUM_QUEUES];
    logic [1:0] rd_ptr_q [NUM_QUEUES];
    logic [1:0] rd_ptr_d [NUM_QUEUES];
    logic [2:0] cnt_q [NUM_QUEUES];
    logic [2:0] cnt_d [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] empty, wr_en, rd_en, elig;
    logic [QW-1:0] cur_idx;
    logic [WW-1:0] head;
    logic rd, is_eop, found;

    // Reset asserts asynchronously, releases two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            rst_n_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            rst_n_q <= sync1_q;
        end
    end

    assign cur_idx   = cur_queue_q[QW-1:0];
    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_wr    = out_wr_q;
    assign cur_queue = cur_queue_q;
    assign pkt_done  = pkt_done_q;

    // FIFO status; nearly full at 3 of 4 entries.
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            empty[i]  = cnt_q[i] == 3'd0;
            in_rdy[i] = cnt_q[i] < 3'd3;
            wr_en[i]  = in_wr[i] && cnt_q[i] != 3'd4;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_queue_d  = cur_queue_q;
        last_grant_d = last_grant_q;
        seen_data_d  = seen_data_q;
        out_data_d   = out_data_q;
        out_ctrl_d   = out_ctrl_q;
        out_wr_d     = 1'b0;
        pkt_done_d   = 1'b0;
        rd_en        = '0;
        found        = 1'b0;
        idx          = last_grant_q;
        elig         = ~empty & queue_enable;
        head         = mem_q[cur_idx][rd_ptr_q[cur_idx]];
        rd           = state_q == XFER && out_rdy && !empty[cur_idx];
        // EOP: a non-zero ctrl word once payload has been seen.
        is_eop       = rd && head[DATA_WIDTH +: CTRL_WIDTH] != '0 && seen_data_q;
        if (state_q == IDLE) begin
`ifdef PKT_ARB_STRICT_PRIO_EN
            // Queue 0 bypasses the rotation and leaves last_grant untouched.
            if (elig[0]) begin
                found       = 1'b1;
                cur_queue_d = 3'd0;
            end
`endif
            for (int i = 0; i < NUM_QUEUES; i++) begin
                idx = idx == LAST_Q ? 3'd0 : idx + 3'd1;
                if (!found && elig[idx[QW-1:0]]) begin
                    found        = 1'b1;
                    cur_queue_d  = idx;
                    last_grant_d = idx;
                end
            end
            if (found) begin
                state_d     = XFER;
                seen_data_d = 1'b0;
            end
        end else if (rd) begin
            rd_en[cur_idx] = 1'b1;
            out_wr_d       = 1'b1;
            out_data_d     = head[DATA_WIDTH-1:0];
            out_ctrl_d     = head[DATA_WIDTH +: CTRL_WIDTH];
            pkt_done_d     = is_eop;
            seen_data_d    = seen_data_q || head[DATA_WIDTH +: CTRL_WIDTH] == '0;
            state_d        = is_eop ? IDLE : XFER;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (wr_en[i]) begin
                mem_d[i][wr_ptr_q[i]] = {in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
                wr_ptr_d[i] = wr_ptr_q[i] + 2'd1;
            end
            if (rd_en[i]) rd_ptr_d[i] = rd_ptr_q[i] + 2'd1;
            cnt_d[i] = cnt_q[i] + {2'b0, wr_en[i]} - {2'b0, rd_en[i]};
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q      <= IDLE;
            cur_queue_q  <= '0;
            last_grant_q <= LAST_Q;
            seen_data_q  <= 1'b0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            out_wr_q     <= 1'b0;
            pkt_done_q   <= 1'b0;
            wr_ptr_q     <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            cnt_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            cur_queue_q  <= cur_queue_d;
            last_grant_q <= last_grant_d;
            seen_data_q  <= seen_data_d;
            out_data_q   <= out_data_d;
            out_ctrl_q   <= out_ctrl_d;
            out_wr_q     <= out_wr_d;
            pkt_done_q   <= pkt_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pkt_gen_output_arbiter.sv
// tb_pkt_gen_output_arbiter: random and directed stimulus against a packet-level reference model.
module tb_pkt_gen_output_arbiter;
    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int CW = 8;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          e;
    } word_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [NQ*DW-1:0] in_data;
    logic [NQ*CW-1:0] in_ctrl;
    logic [NQ-1:0] in_wr, in_rdy, queue_enable;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic out_wr, out_rdy, pkt_done;
    logic [2:0] cur_queue;

    always #5 clk = ~clk;

    pkt_gen_output_arbiter #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .in_rdy(in_rdy), .queue_enable(queue_enable), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_wr(out_wr), .out_rdy(out_rdy), .cur_queue(cur_queue), .pkt_done(pkt_done)
    );

    word_t src [NQ][$];
    word_t exp_q [NQ][$];
    int occ [NQ] = '{default: 0};
    logic [NQ-1:0] wrote = '0;
    logic [NQ-1:0] en = '0;
    logic [3:0] pat = 4'b1001;
    int total = 0, bad = 0, cyc = 0, g = 0, last = NQ - 1;
    int wr_pct = 100, rdy_pct = 100, first_out = -1, t0 = 0;
    bit busy = 0, gap = 0, gen = 0, rdy_pat = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_word(input int q, input logic [CW-1:0] c, input logic e);
        word_t w;
        w.c = c;
        w.d = {$urandom, $urandom};
        w.e = e;
        src[q].push_back(w);
    endtask

    // Header words (ctrl != 0), payload (ctrl == 0), then one EOP word (ctrl != 0).
    task automatic make_pkt(input int q, input int nh, input int np);
        for (int i = 0; i < nh; i++) push_word(q, 8'($urandom_range(1, 255)), 1'b0);
        for (int i = 0; i < np; i++) push_word(q, 8'h00, 1'b0);
        push_word(q, 8'($urandom_range(1, 255)), 1'b1);
    endtask

    task automatic tick();
        word_t w;
        logic [NQ-1:0] rdy_exp;
        @(posedge clk);
        #1;
        cyc++;
        for (int q = 0; q < NQ; q++) if (wrote[q]) occ[q]++;
        wrote = '0;
        if (!out_rdy) check("rdy_low_wr", out_wr, 0);
        if (gap) check("pkt_gap", out_wr, 0);
        gap = 0;
        if (out_wr) begin
            if (first_out < 0) first_out = cyc;
            if (!busy) check("spurious_wr", out_wr, 0);
            else if (exp_q[g].size() == 0) check("underflow", exp_q[g].size(), 1);
            else begin
                w = exp_q[g].pop_front();
                occ[g]--;
                check("cur_queue", cur_queue, g);
                check("out_data", out_data, w.d);
                check("out_ctrl", out_ctrl, w.c);
                check("pkt_done", pkt_done, w.e);
                if (w.e) begin
                    busy = 0;
                    gap = 1;
                end
            end
        end else check("pkt_done_idle", pkt_done, 0);
        for (int q = 0; q < NQ; q++) rdy_exp[q] = occ[q] < 3;
        check("in_rdy", in_rdy, rdy_exp);
    endtask

    // Drive this cycle's inputs, then apply the arbitration rule if the arbiter is idle.
    task automatic drive();
        word_t w;
        logic [NQ-1:0] elig;
        out_rdy = rdy_pat ? pat[cyc % 4] : ($urandom_range(0, 99) < rdy_pct);
        queue_enable = en;
        for (int q = 0; q < NQ; q++) begin
            if (gen && src[q].size() == 0) make_pkt(q, $urandom_range(0, 2), $urandom_range(1, 4));
            in_wr[q] = 1'b0;
            if (src[q].size() != 0 && in_rdy[q] && $urandom_range(0, 99) < wr_pct) begin
                w = src[q].pop_front();
                in_data[q*DW +: DW] = w.d;
                in_ctrl[q*CW +: CW] = w.c;
                in_wr[q] = 1'b1;
                wrote[q] = 1'b1;
                exp_q[q].push_back(w);
            end
        end
        if (!busy) begin
            for (int q = 0; q < NQ; q++) elig[q] = occ[q] > 0 && queue_enable[q];
`ifdef PKT_ARB_STRICT_PRIO_EN
            if (elig[0]) begin
                busy = 1;
                g = 0;
            end
`endif
            for (int i = 1; i <= NQ && !busy; i++) begin
                if (elig[(last + i) % NQ]) begin
                    busy = 1;
                    g = (last + i) % NQ;
                    last = g;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            drive();
        end
    endtask

    task automatic drain();
        int left;
        gen = 0;
        en = '1;
        rdy_pct = 100;
        wr_pct = 100;
        for (int k = 0; k < 400; k++) begin
            left = int'(busy);
            for (int q = 0; q < NQ; q++) left += src[q].size() + exp_q[q].size();
            if (left == 0) break;
            tick();
            drive();
        end
        left = int'(busy);
        for (int q = 0; q < NQ; q++) left += src[q].size() + exp_q[q].size();
        check("drain_left", left, 0);
    endtask

    initial begin
        in_data = '0;
        in_ctrl = '0;
        in_wr = '0;
        queue_enable = '0;
        out_rdy = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_wr", out_wr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_cur_queue", cur_queue, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_in_rdy", in_rdy, 4'hF);
        @(negedge clk) reset_n = 1'b1;
        repeat (4) tick();

        // Single packet on queue 1: FF, 00, 01.
        en = '1;
        push_word(1, 8'hFF, 1'b0);
        push_word(1, 8'h00, 1'b0);
        push_word(1, 8'h01, 1'b1);
        first_out = -1;
        drive();
        t0 = cyc;
        run(20);
        check("latency", first_out - t0, 3);
        check("pkt1_left", exp_q[1].size() + src[1].size(), 0);

        // All queues continuously loaded: round-robin order.
        gen = 1;
        run(200);
        drain();

        // out_rdy pattern 1,0,0,1 during a 6-word packet.
        make_pkt(0, 1, 4);
        rdy_pat = 1;
        run(40);
        rdy_pat = 0;
        check("toggle_left", exp_q[0].size() + src[0].size(), 0);

        // Disable queue 2 in the middle of one of its packets.
        gen = 1;
        begin
            int k = 0;
            while (k < 300 && !(out_wr && cur_queue == 3'd2)) begin
                tick();
                drive();
                k++;
            end
        end
        check("q2_seen", cur_queue, 2);
        en = 4'b1011;
        run(80);
        en = '1;
        run(40);

        // Random traffic, backpressure and enables.
        rdy_pct = 70;
        wr_pct = 60;
        for (int p = 0; p < 48; p++) begin
            en = 4'($urandom_range(0, 15));
            run(25);
        end
        drain();

        // Reset pulse mid-packet.
        gen = 1;
        begin
            int k = 0;
            while (k < 300 && !(busy && out_wr)) begin
                tick();
                drive();
                k++;
            end
        end
        check("midpkt_wr", out_wr, 1);
        #2 reset_n = 1'b0;
        in_wr = '0;
        #1;
        check("rst_async_wr", out_wr, 0);
        check("rst_async_rdy", in_rdy, 4'hF);
        for (int q = 0; q < NQ; q++) begin
            src[q].delete();
            exp_q[q].delete();
            occ[q] = 0;
        end
        wrote = '0;
        busy = 0;
        gap = 0;
        last = NQ - 1;
        gen = 0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        run(4);
        make_pkt(3, 1, 2);
        make_pkt(0, 1, 2);
        first_out = -1;
        begin
            int k = 0;
            while (k < 30 && first_out < 0) begin
                tick();
                drive();
                k++;
            end
        end
        check("post_rst_q", cur_queue, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
